// File: rtl/mux_4x1_reg_pkg.sv
// Shared types and constants for the registered 4:1 selector.
package mux_4x1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/mux_4x1_reg_if.sv
// Channel bundle for mux_4x1_reg: four data inputs, select, qualifier and registered result.
// out_parity exists only when MUX_4X1_REG_PARITY_EN is defined.
interface mux_4x1_reg_if #(parameter int WIDTH = 1);
  import mux_4x1_pkg::*;

  logic [WIDTH-1:0] i0, i1, i2, i3;
  logic             s0, s1;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  sel_t             sel_q;
`ifdef MUX_4X1_REG_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output i0, i1, i2, i3, s0, s1, in_valid,
`ifdef MUX_4X1_REG_PARITY_EN
    input  out_parity,
`endif
    input  out, out_valid, sel_q
  );

  modport slave (
    input  i0, i1, i2, i3, s0, s1, in_valid,
`ifdef MUX_4X1_REG_PARITY_EN
    output out_parity,
`endif
    output out, out_valid, sel_q
  );

endinterface

// File: rtl/mux_4x1_reg_core.sv
// Purely combinational 4:1 word selector; an unresolvable select yields zero.
module mux_4x1_core
  import mux_4x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic [WIDTH-1:0] d2_i,
  input  logic [WIDTH-1:0] d3_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (sel_i)
      SEL_I0:  y_o = d0_i;
      SEL_I1:  y_o = d1_i;
      SEL_I2:  y_o = d2_i;
      SEL_I3:  y_o = d3_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mux_4x1_reg.sv
// Registered 4:1 channel selector with one-cycle latency and a one-shot valid flag.
// Optional registered even parity of the selected word under MUX_4X1_REG_PARITY_EN.
module mux_4x1_reg
  import mux_4x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_4x1_reg_if.slave bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_chk
    $error("mux_4x1_reg: WIDTH must lie in 1..MAX_WIDTH");
  end

  sel_t             sel_in, sel_d, sel_q;
  logic [WIDTH-1:0] mux_w, out_d, out_q;
  logic             vld_d, vld_q;

  assign sel_in = {bus.s1, bus.s0};

  mux_4x1_core #(.WIDTH(WIDTH)) u_core (
    .sel_i (sel_in),
    .d0_i  (bus.i0),
    .d1_i  (bus.i1),
    .d2_i  (bus.i2),
    .d3_i  (bus.i3),
    .y_o   (mux_w)
  );

  always_comb begin
    out_d = out_q;
    sel_d = sel_q;
    vld_d = bus.in_valid;
    if (bus.in_valid) begin
      out_d = mux_w;
      // An unknown select is recorded as channel 0, matching the zero data word.
      case (sel_in)
        SEL_I0, SEL_I1, SEL_I2, SEL_I3: sel_d = sel_in;
        default:                        sel_d = SEL_I0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= SEL_I0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      vld_q <= vld_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.sel_q     = sel_q;
  assign bus.out_valid = vld_q;

`ifdef MUX_4X1_REG_PARITY_EN
  logic par_d, par_q;

  assign par_d = bus.in_valid ? ^mux_w : par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign bus.out_parity = par_q;
`endif

endmodule

// File: tb/tb_mux_4x1_reg.sv
// Directed self-checking bench for mux_4x1_reg (WIDTH=1 and WIDTH=8 instances).
module tb_mux_4x1_reg;
  import mux_4x1_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_4x1_reg_if #(.WIDTH(1)) b1 ();
  mux_4x1_reg_if #(.WIDTH(8)) b8 ();

  mux_4x1_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mux_4x1_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  typedef struct {
    logic [7:0] i0, i1, i2, i3;
    logic [1:0] sel;
    logic       v;
    logic [7:0] eo;
    logic       ev;
    logic [1:0] es;
    logic       ep;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d,
                              logic [1:0] s, logic v, logic [7:0] eo, logic ev,
                              logic [1:0] es, logic ep);
    vec_t r;
    r.i0 = a; r.i1 = b; r.i2 = c; r.i3 = d;
    r.sel = s; r.v = v; r.eo = eo; r.ev = ev; r.es = es; r.ep = ep;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.i0 = '0; b1.i1 = '0; b1.i2 = '0; b1.i3 = '0;
    b1.s0 = 1'b0; b1.s1 = 1'b0; b1.in_valid = 1'b0;
    b8.i0 = '0; b8.i1 = '0; b8.i2 = '0; b8.i3 = '0;
    b8.s0 = 1'b0; b8.s1 = 1'b0; b8.in_valid = 1'b0;

    //                i0     i1     i2     i3    sel   v   out   vld  selq  par
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd0, 1, 8'h01, 1, 2'd0, 1));
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd1, 1, 8'h07, 1, 2'd1, 1));
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd2, 1, 8'hA5, 1, 2'd2, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd3, 1, 8'h3C, 1, 2'd3, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd1, 0, 8'h3C, 0, 2'd3, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'hA5, 8'h3C, 2'd2, 1, 8'hA5, 1, 2'd2, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'h3C, 8'h3C, 2'd2, 0, 8'hA5, 0, 2'd2, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'h3C, 8'h00, 2'd0, 1, 8'h01, 1, 2'd0, 1));
    tbl.push_back(mk(8'h01, 8'h07, 8'h3C, 8'hFF, 2'd3, 1, 8'hFF, 1, 2'd3, 0));
    tbl.push_back(mk(8'h01, 8'h07, 8'h3C, 8'hFF, 2'd1, 1, 8'h07, 1, 2'd1, 1));
    tbl.push_back(mk(8'h01, 8'h03, 8'h3C, 8'hFF, 2'd1, 1, 8'h03, 1, 2'd1, 0));
    tbl.push_back(mk(8'hFF, 8'h03, 8'h3C, 8'hFF, 2'd0, 1, 8'hFF, 1, 2'd0, 0));
    tbl.push_back(mk(8'hFF, 8'h03, 8'h3C, 8'h12, 2'd3, 0, 8'hFF, 0, 2'd0, 0));

    // Reset values while rst_n is held low from time zero
    #2;
    chk("rst b1.out", b1.out, 0);
    chk("rst b1.out_valid", b1.out_valid, 0);
    chk("rst b8.out", b8.out, 0);
    chk("rst b8.out_valid", b8.out_valid, 0);
    chk("rst b8.sel_q", b8.sel_q, 0);
`ifdef MUX_4X1_REG_PARITY_EN
    chk("rst b8.out_parity", b8.out_parity, 0);
`endif
    #10 rst_n = 1'b1;

    foreach (tbl[k]) begin
      b8.i0 = tbl[k].i0; b8.i1 = tbl[k].i1; b8.i2 = tbl[k].i2; b8.i3 = tbl[k].i3;
      b8.s1 = tbl[k].sel[1]; b8.s0 = tbl[k].sel[0]; b8.in_valid = tbl[k].v;
      tick();
      chk($sformatf("vec%0d out", k), b8.out, tbl[k].eo);
      chk($sformatf("vec%0d out_valid", k), b8.out_valid, tbl[k].ev);
      chk($sformatf("vec%0d sel_q", k), b8.sel_q, tbl[k].es);
`ifdef MUX_4X1_REG_PARITY_EN
      chk($sformatf("vec%0d out_parity", k), b8.out_parity, tbl[k].ep);
`endif
    end
    b8.in_valid = 1'b0;

    // WIDTH=1 select sweep, back-to-back accepts
    b1.i0 = 1'b0; b1.i1 = 1'b1; b1.i2 = 1'b0; b1.i3 = 1'b1; b1.in_valid = 1'b1;
    for (int s = 0; s < 4; s++) begin
      b1.s1 = s[1]; b1.s0 = s[0];
      tick();
      chk($sformatf("sweep%0d out", s), b1.out, s[0]);
      chk($sformatf("sweep%0d out_valid", s), b1.out_valid, 1);
      chk($sformatf("sweep%0d sel_q", s), b1.sel_q, s);
    end

    // Asynchronous reset mid-cycle while out=1, out_valid=1
    #3 rst_n = 1'b0;
    #1;
    chk("async b1.out", b1.out, 0);
    chk("async b1.out_valid", b1.out_valid, 0);
    chk("async b1.sel_q", b1.sel_q, 0);
    b1.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Reset during back-to-back accepts on the 8-bit instance
    b8.i1 = 8'h07; b8.i2 = 8'hA5; b8.s1 = 1'b0; b8.s0 = 1'b1; b8.in_valid = 1'b1;
    tick();
    chk("stream out", b8.out, 8'h07);
    chk("stream out_valid", b8.out_valid, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out", b8.out, 0);
    chk("midrst out_valid", b8.out_valid, 0);
    tick();
    chk("inrst out", b8.out, 0);
    chk("inrst out_valid", b8.out_valid, 0);
    b8.in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("postrst1 out", b8.out, 0);
    chk("postrst1 out_valid", b8.out_valid, 0);
    chk("postrst1 sel_q", b8.sel_q, 0);
    tick();
    chk("postrst2 out_valid", b8.out_valid, 0);
    b8.s1 = 1'b1; b8.s0 = 1'b0; b8.in_valid = 1'b1;
    tick();
    chk("firstacc out", b8.out, 8'hA5);
    chk("firstacc out_valid", b8.out_valid, 1);
    chk("firstacc sel_q", b8.sel_q, 2);
    b8.in_valid = 1'b0;
    b8.i2 = 8'h3C;
    tick();
    chk("idle out", b8.out, 8'hA5);
    chk("idle out_valid", b8.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_4x1_reg.md
Name: mux_4x1_reg

Overview:
- Registered 4:1 selector.
- Picks one of four WIDTH-bit data inputs using a 2-bit select formed from s1 (MSB) and s0 (LSB).
- Presents the chosen word one clock later with a valid flag.
- Sits in datapaths as a glitch-free, timing-isolated channel selector; one clock, asynchronous active-low reset.

Parameters:
- WIDTH, 1, bit width of each data input and of out (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock, the block's only clock
- rst_n  input  1  asynchronous active-low reset; assertion is immediate, release is synchronised by the integrator
- i0  input  WIDTH  data channel 0
- i1  input  WIDTH  data channel 1
- i2  input  WIDTH  data channel 2
- i3  input  WIDTH  data channel 3
- s0  input  1  select bit 0 (LSB)
- s1  input  1  select bit 1 (MSB)
- in_valid  input  1  sample qualifier; capture occurs only when high
- out  output  WIDTH  registered selected data
- out_valid  output  1  high for exactly one cycle after each accepted sample
- sel_q  output  2  registered copy of {s1,s0} used for the word currently on out

Behaviour:
- Select mapping, sel = {s1,s0}:
  - 2'b00 selects i0
  - 2'b01 selects i1
  - 2'b10 selects i2
  - 2'b11 selects i3
- Reset: while rst_n is low, out = 0, out_valid = 0 and sel_q = 2'b00, all asynchronously.
- Reset mid-operation clears all three outputs at once, and any in-flight sample is discarded.
- Accept: at a rising clk edge with in_valid = 1:
  - out <= selected input
  - sel_q <= {s1,s0}
  - out_valid <= 1
- Latency is exactly 1 cycle from sampled inputs to out.
- Idle: at a rising edge with in_valid = 0:
  - out and sel_q hold their previous values
  - out_valid <= 0
- Back-to-back accepts every cycle are supported with no bubbles; full throughput.
- Data or select changes between edges have no effect on outputs. There is no combinational path from any input to any output.
- Select and data are sampled on the same edge. A select change coincident with a data change uses the new values of both.
- Unknown (X/Z) select in simulation: out <= 0 and sel_q <= 2'b00. Synthesis treats this as don't-care via a default branch.
- No back-pressure: the consumer must accept out whenever out_valid is high.

Optional Feature:
- Macro: MUX_4X1_REG_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit), registered alongside out.
  - out_parity is the even parity (XOR reduction) of the selected WIDTH-bit word.
  - Resets to 0; holds on idle cycles; updates only on accept.
- When undefined: the port is absent and the logic is omitted. All other behaviour is identical.

Decomposition:
- Package mux_4x1_pkg holds:
  - typedef sel_t as a 2-bit logic
  - constants SEL_I0 = 2'd0, SEL_I1 = 2'd1, SEL_I2 = 2'd2, SEL_I3 = 2'd3
  - constant MAX_WIDTH = 64
- Sub-module mux_4x1_core: purely combinational 4:1 selector taking sel_t and four WIDTH-bit inputs.
- mux_4x1_reg instantiates mux_4x1_core and adds the output registers, valid and optional parity.
- A WIDTH range check (1..MAX_WIDTH) lives in an initial/elaboration assertion.

Test Plan:
- Reset: drive rst_n = 0 mid-cycle with out = 1 and out_valid = 1 -> out = 0, out_valid = 0 and sel_q = 00 immediately, without waiting for a clk edge.
- Select sweep, WIDTH = 1: i0 = 0, i1 = 1, i2 = 0, i3 = 1, in_valid = 1; apply {s1,s0} = 00, 01, 10, 11 on consecutive edges -> out = 0, 1, 0, 1 one cycle later each, with out_valid = 1 for 4 consecutive cycles.
- Hold: after accepting i2 = 8'hA5 with sel = 10 (WIDTH = 8), set in_valid = 0 and change i2 to 8'h3C -> out stays 8'hA5, sel_q stays 10, out_valid = 0.
- Coincident change, WIDTH = 8: on one edge switch sel 00 -> 11 while i3 changes 8'h00 -> 8'hFF -> out = 8'hFF and sel_q = 11 on the next cycle.
- Parity (macro defined), WIDTH = 8: select i1 = 8'h07 -> out_parity = 1; then select i1 = 8'h03 -> out_parity = 0.
- Reset mid-stream: assert rst_n low during back-to-back accepts, then release -> outputs stay 0 until the first accept after release, and out_valid rises exactly one cycle after that accept.
